// File: rtl/ci_px_walker_pkg.sv
// rtl/ci_px_walker_pkg.sv - shared display geometry for the character-index walker
package ci_px_walker_pkg;

  localparam int FONT_W_D   = 10;
  localparam int FONT_H_D   = 12;
  localparam int SCREEN_W_D = 640;
  localparam int SCREEN_H_D = 480;

  localparam int NCW = SCREEN_W_D / FONT_W_D;
  localparam int NCH = SCREEN_H_D / FONT_H_D;
  localparam int NC  = NCW * NCH;
  localparam int CIW = $clog2(NC);
  localparam int XW  = $clog2(SCREEN_W_D);
  localparam int YW  = $clog2(SCREEN_H_D);
  localparam int FXW = $clog2(FONT_W_D);
  localparam int FYW = $clog2(FONT_H_D);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } walk_state_t;

endpackage

// File: rtl/ci_px_walker_if.sv
// rtl/ci_px_walker_if.sv - index-in / pixel-beat-out handshake bundle
interface ci_px_walker_if #(
  parameter int CIW = ci_px_walker_pkg::CIW,
  parameter int XW  = ci_px_walker_pkg::XW,
  parameter int YW  = ci_px_walker_pkg::YW,
  parameter int FXW = ci_px_walker_pkg::FXW,
  parameter int FYW = ci_px_walker_pkg::FYW
);
  logic           ci_valid;
  logic [CIW-1:0] ci;
  logic           ci_ready;
  logic           p_valid;
  logic           p_ready;
  logic [XW-1:0]  px;
  logic [YW-1:0]  py;
  logic [FXW-1:0] fx;
  logic [FYW-1:0] fy;
  logic           p_last;
  logic           err;

  // Upstream index source plus downstream pixel sink
  modport master (
    output ci_valid, ci, p_ready,
    input  ci_ready, p_valid, px, py, fx, fy, p_last, err
  );

  // The walker itself
  modport slave (
    input  ci_valid, ci, p_ready,
    output ci_ready, p_valid, px, py, fx, fy, p_last, err
  );
endinterface

// File: rtl/ci_px_walker_cell_scan_ctr.sv
// rtl/ci_px_walker_cell_scan_ctr.sv - raster counter over one glyph cell
module cell_scan_ctr #(
  parameter int W  = 10,
  parameter int H  = 12,
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          wrap,
  output logic          last
);

  assign wrap = (x == XW'(W - 1));
  assign last = wrap && (y == YW'(H - 1));

  // Step x each enable, carrying into y at the row end; whole cell wraps to 0,0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (wrap) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ci_px_walker.sv
// rtl/ci_px_walker.sv - expands a character index into its glyph pixel coordinates
module ci_px_walker
  import ci_px_walker_pkg::*;
#(
  parameter int FONT_W   = FONT_W_D,
  parameter int FONT_H   = FONT_H_D,
  parameter int SCREEN_W = SCREEN_W_D,
  parameter int SCREEN_H = SCREEN_H_D
) (
  input logic            clk,
  input logic            rst,
  ci_px_walker_if.slave  bus
);

  localparam int CELLS_W = SCREEN_W / FONT_W;
  localparam int CELLS_H = SCREEN_H / FONT_H;
  localparam int CELLS   = CELLS_W * CELLS_H;
  localparam int X_W     = $clog2(SCREEN_W);
  localparam int Y_W     = $clog2(SCREEN_H);
  localparam int FX_W    = $clog2(FONT_W);
  localparam int FY_W    = $clog2(FONT_H);

  walk_state_t     state_q, state_d;
  logic [X_W-1:0]  base_x_q, px_q, new_bx;
  logic [Y_W-1:0]  base_y_q, py_q, new_by;
  logic            err_q;
  logic [FX_W-1:0] fx;
  logic [FY_W-1:0] fy;
  logic            row_wrap, cell_last;
  logic            accept, in_range, start, xfer;
  int              ci_int;

  assign accept   = bus.ci_valid && (state_q == IDLE);
  assign in_range = ci_int < CELLS;
  assign start    = accept && in_range;
  assign xfer     = (state_q == RUN) && bus.p_ready;

  // Cell origin from the index; constant divisor, so no iterative divider
  always_comb begin
    ci_int = int'(bus.ci);
    new_bx = X_W'((ci_int % CELLS_W) * FONT_W);
    new_by = Y_W'((ci_int / CELLS_W) * FONT_H);
  end

  cell_scan_ctr #(
    .W  (FONT_W),
    .H  (FONT_H),
    .XW (FX_W),
    .YW (FY_W)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .en    (xfer),
    .x     (fx),
    .y     (fy),
    .wrap  (row_wrap),
    .last  (cell_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on an in-range accept, finish when the last beat goes out
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (xfer && cell_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Screen coordinates tracked incrementally so px/py come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_x_q <= '0;
      base_y_q <= '0;
      px_q     <= '0;
      py_q     <= '0;
    end else if (start) begin
      base_x_q <= new_bx;
      base_y_q <= new_by;
      px_q     <= new_bx;
      py_q     <= new_by;
    end else if (xfer) begin
      if (row_wrap) begin
        px_q <= base_x_q;
        py_q <= py_q + 1'b1;
      end else begin
        px_q <= px_q + 1'b1;
      end
    end
  end

  // One-cycle pulse for an out-of-range index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && !in_range;
  end

  assign bus.ci_ready = (state_q == IDLE);
  assign bus.p_valid  = (state_q == RUN);
  assign bus.p_last   = (state_q == RUN) && cell_last;
  assign bus.px       = px_q;
  assign bus.py       = py_q;
  assign bus.fx       = fx;
  assign bus.fy       = fy;
  assign bus.err      = err_q;

endmodule
